// File: rtl/alu_core_if.sv
// Operand/command bus and result/flag bus of the ALU core.
// The master drives operands and commands; the slave (the ALU) returns
// results and flags.
interface alu_core_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          ce;
  logic          mode;
  logic [CW-1:0] cmd;
  logic [1:0]    inp_valid;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          cin;
  logic [DW:0]   res;
  logic          err;
  logic          oflow;
  logic          cout;
  logic          g;
  logic          l;
  logic          e;

  modport master (
    output ce, mode, cmd, inp_valid, opa, opb, cin,
    input  res, err, oflow, cout, g, l, e
  );

  modport slave (
    input  ce, mode, cmd, inp_valid, opa, opb, cin,
    output res, err, oflow, cout, g, l, e
  );
endinterface

// File: rtl/alu_core.sv
// ALU datapath with a two-state operand collection FSM.
// Operands may arrive in different cycles; a two-operand command whose
// second operand is missing waits up to 16 cycles for it. Every result
// and flag is registered and changes only on a result or error event.
module alu_core #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  localparam int SW = $clog2(DW);

  // Arithmetic command codes (mode = 1)
  localparam logic [CW-1:0] A_ADD     = CW'(4'd0);
  localparam logic [CW-1:0] A_SUB     = CW'(4'd1);
  localparam logic [CW-1:0] A_ADD_CIN = CW'(4'd2);
  localparam logic [CW-1:0] A_SUB_CIN = CW'(4'd3);
  localparam logic [CW-1:0] A_INC_A   = CW'(4'd4);
  localparam logic [CW-1:0] A_DEC_A   = CW'(4'd5);
  localparam logic [CW-1:0] A_INC_B   = CW'(4'd6);
  localparam logic [CW-1:0] A_DEC_B   = CW'(4'd7);
  localparam logic [CW-1:0] A_CMP     = CW'(4'd8);

  // Logical command codes (mode = 0)
  localparam logic [CW-1:0] L_AND     = CW'(4'd0);
  localparam logic [CW-1:0] L_NAND    = CW'(4'd1);
  localparam logic [CW-1:0] L_OR      = CW'(4'd2);
  localparam logic [CW-1:0] L_NOR     = CW'(4'd3);
  localparam logic [CW-1:0] L_XOR     = CW'(4'd4);
  localparam logic [CW-1:0] L_XNOR    = CW'(4'd5);
  localparam logic [CW-1:0] L_NOT_A   = CW'(4'd6);
  localparam logic [CW-1:0] L_NOT_B   = CW'(4'd7);
  localparam logic [CW-1:0] L_SHR1_A  = CW'(4'd8);
  localparam logic [CW-1:0] L_SHL1_A  = CW'(4'd9);
  localparam logic [CW-1:0] L_SHR1_B  = CW'(4'd10);
  localparam logic [CW-1:0] L_SHL1_B  = CW'(4'd11);
  localparam logic [CW-1:0] L_ROL_A_B = CW'(4'd12);
  localparam logic [CW-1:0] L_ROR_A_B = CW'(4'd13);

  localparam logic [DW:0] ONE_X = {{DW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DW:0] res;
    logic        err;
    logic        oflow;
    logic        cout;
    logic        g;
    logic        l;
    logic        e;
  } out_t;

  localparam out_t OUT_ZERO = {(DW + 7){1'b0}};

  // Operand need of a command: bit0 = A, bit1 = B; 00 marks an unsupported command.
  function automatic logic [1:0] op_need(input logic m, input logic [CW-1:0] c);
    logic [1:0] n;
    n = 2'b00;
    if (m) begin
      case (c)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: n = 2'b11;
        A_INC_A, A_DEC_A:                          n = 2'b01;
        A_INC_B, A_DEC_B:                          n = 2'b10;
        default:                                   n = 2'b00;
      endcase
    end else begin
      case (c)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
        L_ROL_A_B, L_ROR_A_B:                      n = 2'b11;
        L_NOT_A, L_SHR1_A, L_SHL1_A:               n = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B:               n = 2'b10;
        default:                                   n = 2'b00;
      endcase
    end
    return n;
  endfunction

  // Output word of an error event: err alone is set.
  function automatic out_t err_event();
    out_t o;
    o     = OUT_ZERO;
    o.err = 1'b1;
    return o;
  endfunction

  // Full result/flag word of one operation; flags not defined for the op stay 0.
  function automatic out_t op_eval(
    input logic          m,
    input logic [CW-1:0] c,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          ci
  );
    out_t            o;
    logic [DW:0]     ax;
    logic [DW:0]     bx;
    logic [DW:0]     cx;
    logic [2*DW-1:0] rot;
    logic [SW-1:0]   sh;
    o   = OUT_ZERO;
    ax  = {1'b0, a};
    bx  = {1'b0, b};
    cx  = {{DW{1'b0}}, ci};
    rot = {(2 * DW){1'b0}};
    sh  = b[SW-1:0];
    if (m) begin
      case (c)
        A_ADD:     begin o.res = ax + bx;      o.cout  = o.res[DW]; end
        A_SUB:     begin o.res = ax - bx;      o.oflow = o.res[DW]; end
        A_ADD_CIN: begin o.res = ax + bx + cx; o.cout  = o.res[DW]; end
        A_SUB_CIN: begin o.res = ax - bx - cx; o.oflow = o.res[DW]; end
        A_INC_A:   begin o.res = ax + ONE_X;   o.cout  = o.res[DW]; end
        A_DEC_A:   begin o.res = ax - ONE_X;   o.oflow = o.res[DW]; end
        A_INC_B:   begin o.res = bx + ONE_X;   o.cout  = o.res[DW]; end
        A_DEC_B:   begin o.res = bx - ONE_X;   o.oflow = o.res[DW]; end
        A_CMP: begin
          o.g = (a > b);
          o.l = (a < b);
          o.e = (a == b);
        end
        default:   o.err = 1'b1;
      endcase
    end else begin
      case (c)
        L_AND:    o.res = {1'b0, a & b};
        L_NAND:   o.res = {1'b0, ~(a & b)};
        L_OR:     o.res = {1'b0, a | b};
        L_NOR:    o.res = {1'b0, ~(a | b)};
        L_XOR:    o.res = {1'b0, a ^ b};
        L_XNOR:   o.res = {1'b0, ~(a ^ b)};
        L_NOT_A:  o.res = {1'b0, ~a};
        L_NOT_B:  o.res = {1'b0, ~b};
        L_SHR1_A: o.res = {2'b00, a[DW-1:1]};
        L_SHL1_A: o.res = {1'b0, a[DW-2:0], 1'b0};
        L_SHR1_B: o.res = {2'b00, b[DW-1:1]};
        L_SHL1_B: o.res = {1'b0, b[DW-2:0], 1'b0};
        L_ROL_A_B: begin
          // Upper half of the doubled word shifted left is the left rotation.
          rot   = {a, a} << sh;
          o.res = {1'b0, rot[2*DW-1:DW]};
          o.err = ((b >> SW) != {DW{1'b0}});
        end
        L_ROR_A_B: begin
          // Lower half of the doubled word shifted right is the right rotation.
          rot   = {a, a} >> sh;
          o.res = {1'b0, rot[DW-1:0]};
          o.err = ((b >> SW) != {DW{1'b0}});
        end
        default:  o.err = 1'b1;
      endcase
    end
    return o;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] lat_a_q, lat_a_d;
  logic [DW-1:0] lat_b_q, lat_b_d;
  logic [CW-1:0] lat_cmd_q, lat_cmd_d;
  logic          lat_mode_q, lat_mode_d;
  logic          lat_cin_q, lat_cin_d;
  logic          have_a_q, have_a_d;
  out_t          out_q, out_d;
  logic [1:0]    need;

  assign need = op_need(bus.mode, bus.cmd);

  // Next-state, latch and output decisions for both FSM states.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_cmd_d  = lat_cmd_q;
    lat_mode_d = lat_mode_q;
    lat_cin_d  = lat_cin_q;
    have_a_d   = have_a_q;
    out_d      = out_q;
    if (bus.ce) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.inp_valid == 2'b00) begin
            out_d = err_event();
          end else if (need == 2'b00) begin
            out_d = err_event();
          end else if ((bus.inp_valid & need) == need) begin
            out_d = op_eval(bus.mode, bus.cmd, bus.opa, bus.opb, bus.cin);
          end else if (need == 2'b11) begin
            // Exactly one operand of a two-operand op: park it and wait.
            lat_a_d    = bus.opa;
            lat_b_d    = bus.opb;
            lat_cmd_d  = bus.cmd;
            lat_mode_d = bus.mode;
            lat_cin_d  = bus.cin;
            have_a_d   = bus.inp_valid[0];
            cnt_d      = 4'd0;
            state_d    = ST_WAIT;
          end else begin
            out_d = err_event();
          end
        end
        ST_WAIT: begin
          if (have_a_q && bus.inp_valid[1]) begin
            out_d   = op_eval(lat_mode_q, lat_cmd_q, lat_a_q, bus.opb, lat_cin_q);
            state_d = ST_IDLE;
          end else if (!have_a_q && bus.inp_valid[0]) begin
            out_d   = op_eval(lat_mode_q, lat_cmd_q, bus.opa, lat_b_q, lat_cin_q);
            state_d = ST_IDLE;
          end else if (cnt_q == 4'd15) begin
            // Sixteenth WAIT cycle without the missing operand.
            out_d   = err_event();
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, latches and registered outputs; clock enable low holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      lat_a_q    <= {DW{1'b0}};
      lat_b_q    <= {DW{1'b0}};
      lat_cmd_q  <= {CW{1'b0}};
      lat_mode_q <= 1'b0;
      lat_cin_q  <= 1'b0;
      have_a_q   <= 1'b0;
      out_q      <= OUT_ZERO;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_mode_q <= lat_mode_d;
      lat_cin_q  <= lat_cin_d;
      have_a_q   <= have_a_d;
      out_q      <= out_d;
    end
  end

  assign bus.res   = out_q.res;
  assign bus.err   = out_q.err;
  assign bus.oflow = out_q.oflow;
  assign bus.cout  = out_q.cout;
  assign bus.g     = out_q.g;
  assign bus.l     = out_q.l;
  assign bus.e     = out_q.e;

endmodule
